// File: rtl/hazard_trap_ctrl_if.sv
// rtl/hazard_trap_ctrl_if.sv - pipeline-side signal bundle for hazard_trap_ctrl
interface hazard_trap_ctrl_if;
   logic        ID_valid;
   logic [31:0] ID_PC_plus4;
   logic [4:0]  ID_Rs;
   logic [4:0]  ID_Rt;
   logic        ID_Z;
   logic        ID_J;
   logic        ID_JR;
   logic        ID_Eret;
   logic        ID_Illegal;
   logic        EX_MemRead;
   logic [4:0]  EX_WriteRegister;
   logic        irq;
   logic        PC_IF_ID_Write;
   logic        IF_ID_Flush;
   logic        ID_EX_Flush;
   logic [2:0]  pc_sel;
   logic [31:0] pc_target;
   logic [31:0] epc;
   logic        in_kernel;
   logic        irq_ack;
   logic        double_fault;

   modport master (
      output ID_valid, ID_PC_plus4, ID_Rs, ID_Rt, ID_Z, ID_J, ID_JR,
             ID_Eret, ID_Illegal, EX_MemRead, EX_WriteRegister, irq,
      input  PC_IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pc_sel, pc_target,
             epc, in_kernel, irq_ack, double_fault
   );

   modport slave (
      input  ID_valid, ID_PC_plus4, ID_Rs, ID_Rt, ID_Z, ID_J, ID_JR,
             ID_Eret, ID_Illegal, EX_MemRead, EX_WriteRegister, irq,
      output PC_IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pc_sel, pc_target,
             epc, in_kernel, irq_ack, double_fault
   );
endinterface

// File: rtl/hazard_trap_ctrl.sv
// rtl/hazard_trap_ctrl.sv - stall/flush, trap entry and eret control with EPC
// Optional IRQ_SYNC_EN: route irq through a 2-flop synchronizer before use.
module hazard_trap_ctrl #(
   parameter logic [31:0] IRQ_VECTOR = 32'h80000004,
   parameter logic [31:0] EXC_VECTOR = 32'h80000008
) (
   input  logic               clk,
   input  logic               rst_n,
   hazard_trap_ctrl_if.slave  bus
);

   typedef enum logic {ST_RUN, ST_KERNEL} state_t;

   state_t      r_state;
   logic [31:0] r_epc;
   logic        r_double_fault;

   logic        w_irq_eff;
   logic        w_lu;
   logic        w_run;
   logic        w_exc_take;
   logic        w_irq_take;
   logic        w_eret_take;
   logic        w_dfault;

   logic        w_pcw;
   logic        w_if_flush;
   logic        w_idex_flush;
   logic [2:0]  w_pc_sel;
   logic [31:0] w_pc_target;
   logic        w_irq_ack;

`ifdef IRQ_SYNC_EN
   logic r_irq_s1;
   logic r_irq_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_s1 <= 1'b0;
         r_irq_s2 <= 1'b0;
      end else begin
         r_irq_s1 <= bus.irq;
         r_irq_s2 <= r_irq_s1;
      end
   end

   assign w_irq_eff = r_irq_s2;
`else
   assign w_irq_eff = bus.irq;
`endif

   assign w_lu = bus.EX_MemRead && (bus.EX_WriteRegister != 5'd0) &&
                 ((bus.EX_WriteRegister == bus.ID_Rs) ||
                  (bus.EX_WriteRegister == bus.ID_Rt));

   assign w_run       = (r_state == ST_RUN);
   assign w_exc_take  = w_run && bus.ID_valid && bus.ID_Illegal;
   assign w_irq_take  = w_run && w_irq_eff && bus.ID_valid && !w_lu && !bus.ID_Illegal;
   assign w_eret_take = !w_run && bus.ID_valid && bus.ID_Eret && !w_lu;
   assign w_dfault    = !w_run && bus.ID_valid && bus.ID_Illegal;

   // Priority: trap > eret > load-use > branch/jump > sequential; all idle in reset.
   always_comb begin
      w_pcw        = 1'b1;
      w_if_flush   = 1'b0;
      w_idex_flush = 1'b0;
      w_pc_sel     = 3'd0;
      w_pc_target  = 32'd0;
      w_irq_ack    = 1'b0;
      if (!rst_n) begin
         w_pcw = 1'b1;
      end else if (w_exc_take) begin
         w_pc_sel     = 3'd5;
         w_pc_target  = EXC_VECTOR;
         w_if_flush   = 1'b1;
         w_idex_flush = 1'b1;
      end else if (w_irq_take) begin
         w_pc_sel     = 3'd4;
         w_pc_target  = IRQ_VECTOR;
         w_if_flush   = 1'b1;
         w_idex_flush = 1'b1;
         w_irq_ack    = 1'b1;
      end else if (w_eret_take) begin
         w_pc_sel     = 3'd6;
         w_pc_target  = r_epc;
         w_if_flush   = 1'b1;
      end else if (w_lu) begin
         w_pcw        = 1'b0;
         w_idex_flush = 1'b1;
      end else if (bus.ID_Z) begin
         w_pc_sel     = 3'd1;
         w_if_flush   = 1'b1;
      end else if (bus.ID_J) begin
         w_pc_sel     = 3'd2;
         w_if_flush   = 1'b1;
      end else if (bus.ID_JR) begin
         w_pc_sel     = 3'd3;
         w_if_flush   = 1'b1;
      end
   end

   // An exception resumes after the faulting instruction; an interrupt replays it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_RUN;
         r_epc          <= 32'd0;
         r_double_fault <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_exc_take) begin
                  r_epc   <= bus.ID_PC_plus4;
                  r_state <= ST_KERNEL;
               end else if (w_irq_take) begin
                  r_epc   <= bus.ID_PC_plus4 - 32'd4;
                  r_state <= ST_KERNEL;
               end
            end
            ST_KERNEL: begin
               if (w_dfault) begin
                  r_double_fault <= 1'b1;
               end
               if (w_eret_take) begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign bus.PC_IF_ID_Write = w_pcw;
   assign bus.IF_ID_Flush    = w_if_flush;
   assign bus.ID_EX_Flush    = w_idex_flush;
   assign bus.pc_sel         = w_pc_sel;
   assign bus.pc_target      = w_pc_target;
   assign bus.irq_ack        = w_irq_ack;
   assign bus.epc            = r_epc;
   assign bus.in_kernel      = (r_state == ST_KERNEL);
   assign bus.double_fault   = r_double_fault;

endmodule

// File: tb/tb_hazard_trap_ctrl.sv
// tb/tb_hazard_trap_ctrl.sv - directed self-checking bench for hazard_trap_ctrl
module tb_hazard_trap_ctrl;

`ifdef IRQ_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic clk;
   logic rst_n;
   int   vectors;
   int   errs;

   hazard_trap_ctrl_if bus_if ();

   hazard_trap_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus_if.ID_valid         = 1'b1;
      bus_if.ID_PC_plus4      = 32'h0000_0010;
      bus_if.ID_Rs            = 5'd1;
      bus_if.ID_Rt            = 5'd2;
      bus_if.ID_Z             = 1'b0;
      bus_if.ID_J             = 1'b0;
      bus_if.ID_JR            = 1'b0;
      bus_if.ID_Eret          = 1'b0;
      bus_if.ID_Illegal       = 1'b0;
      bus_if.EX_MemRead       = 1'b0;
      bus_if.EX_WriteRegister = 5'd0;
   endtask

   task automatic set_lu(input logic on);
      bus_if.EX_MemRead       = on;
      bus_if.EX_WriteRegister = on ? 5'd5 : 5'd0;
      bus_if.ID_Rs            = on ? 5'd5 : 5'd1;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      vectors = 0;
      errs    = 0;
      rst_n   = 1'b0;
      idle_inputs();
      bus_if.irq = 1'b1;
      set_lu(1'b1);
      #12;
      chk("rst_pcw",      {31'd0, bus_if.PC_IF_ID_Write}, 32'd1);
      chk("rst_idex",     {31'd0, bus_if.ID_EX_Flush},    32'd0);
      chk("rst_ifid",     {31'd0, bus_if.IF_ID_Flush},    32'd0);
      chk("rst_pcsel",    {29'd0, bus_if.pc_sel},         32'd0);
      chk("rst_target",   bus_if.pc_target,               32'd0);
      chk("rst_ack",      {31'd0, bus_if.irq_ack},        32'd0);
      chk("rst_epc",      bus_if.epc,                     32'd0);
      chk("rst_kernel",   {31'd0, bus_if.in_kernel},      32'd0);
      chk("rst_dfault",   {31'd0, bus_if.double_fault},   32'd0);

      // load-use stall
      @(negedge clk);
      rst_n = 1'b1;
      bus_if.irq = 1'b0;
      idle_inputs();
      set_lu(1'b1);
      #1;
      chk("lu_pcw",   {31'd0, bus_if.PC_IF_ID_Write}, 32'd0);
      chk("lu_idex",  {31'd0, bus_if.ID_EX_Flush},    32'd1);
      chk("lu_ifid",  {31'd0, bus_if.IF_ID_Flush},    32'd0);
      chk("lu_pcsel", {29'd0, bus_if.pc_sel},         32'd0);
      next_cycle();
      set_lu(1'b0);
      #1;
      chk("lu_done_pcw",  {31'd0, bus_if.PC_IF_ID_Write}, 32'd1);
      chk("lu_done_idex", {31'd0, bus_if.ID_EX_Flush},    32'd0);
      next_cycle();
      bus_if.EX_MemRead = 1'b1;
      bus_if.EX_WriteRegister = 5'd0;
      bus_if.ID_Rs = 5'd0;
      #1;
      chk("lu_r0_pcw", {31'd0, bus_if.PC_IF_ID_Write}, 32'd1);

      // branch / jump priority
      next_cycle();
      idle_inputs();
      bus_if.ID_Z = 1'b1;
      bus_if.ID_J = 1'b1;
      #1;
      chk("br_zj_sel",  {29'd0, bus_if.pc_sel},      32'd1);
      chk("br_zj_ifid", {31'd0, bus_if.IF_ID_Flush}, 32'd1);
      chk("br_zj_idex", {31'd0, bus_if.ID_EX_Flush}, 32'd0);
      next_cycle();
      bus_if.ID_Z = 1'b0;
      bus_if.ID_JR = 1'b1;
      #1;
      chk("br_jjr_sel", {29'd0, bus_if.pc_sel}, 32'd2);
      next_cycle();
      bus_if.ID_J = 1'b0;
      #1;
      chk("br_jr_sel", {29'd0, bus_if.pc_sel}, 32'd3);
      next_cycle();
      bus_if.ID_JR = 1'b0;
      bus_if.ID_Z = 1'b1;
      set_lu(1'b1);
      #1;
      chk("br_lu_sel",  {29'd0, bus_if.pc_sel},      32'd0);
      chk("br_lu_ifid", {31'd0, bus_if.IF_ID_Flush}, 32'd0);

      // eret in RUN is a no-op
      next_cycle();
      idle_inputs();
      bus_if.ID_Eret = 1'b1;
      #1;
      chk("eret_run_sel", {29'd0, bus_if.pc_sel}, 32'd0);
      next_cycle();
      bus_if.ID_Eret = 1'b0;
      #1;
      chk("eret_run_kernel", {31'd0, bus_if.in_kernel}, 32'd0);

      // interrupt waits on bubbles and load-use
      bus_if.irq = 1'b1;
      bus_if.ID_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("irq_bubble_ack", {31'd0, bus_if.irq_ack}, 32'd0);
         next_cycle();
      end
      bus_if.ID_valid = 1'b1;
      set_lu(1'b1);
      #1;
      chk("irq_lu_ack", {31'd0, bus_if.irq_ack}, 32'd0);
      next_cycle();
      set_lu(1'b0);
      bus_if.ID_PC_plus4 = 32'h0000_0040;
      #1;
      chk("irq_ack",    {31'd0, bus_if.irq_ack},     32'd1);
      chk("irq_sel",    {29'd0, bus_if.pc_sel},      32'd4);
      chk("irq_target", bus_if.pc_target,            32'h8000_0004);
      chk("irq_ifid",   {31'd0, bus_if.IF_ID_Flush}, 32'd1);
      chk("irq_idex",   {31'd0, bus_if.ID_EX_Flush}, 32'd1);
      next_cycle();
      bus_if.irq = 1'b0;
      #1;
      chk("irq_epc",    bus_if.epc,                  32'h0000_003C);
      chk("irq_kernel", {31'd0, bus_if.in_kernel},   32'd1);

      // return from interrupt
      bus_if.ID_Eret = 1'b1;
      #1;
      chk("ret1_sel",    {29'd0, bus_if.pc_sel},      32'd6);
      chk("ret1_target", bus_if.pc_target,            32'h0000_003C);
      chk("ret1_idex",   {31'd0, bus_if.ID_EX_Flush}, 32'd0);
      next_cycle();
      bus_if.ID_Eret = 1'b0;
      #1;
      chk("ret1_kernel", {31'd0, bus_if.in_kernel}, 32'd0);
      chk("ret1_epc",    bus_if.epc,                32'h0000_003C);

      // exception taken despite load-use
      next_cycle();
      bus_if.ID_Illegal = 1'b1;
      bus_if.ID_PC_plus4 = 32'h0000_0100;
      set_lu(1'b1);
      #1;
      chk("exc_sel",    {29'd0, bus_if.pc_sel},         32'd5);
      chk("exc_target", bus_if.pc_target,               32'h8000_0008);
      chk("exc_pcw",    {31'd0, bus_if.PC_IF_ID_Write}, 32'd1);
      chk("exc_ifid",   {31'd0, bus_if.IF_ID_Flush},    32'd1);
      chk("exc_idex",   {31'd0, bus_if.ID_EX_Flush},    32'd1);
      next_cycle();
      idle_inputs();
      bus_if.irq = 1'b1;
      #1;
      chk("exc_epc",    bus_if.epc,                32'h0000_0100);
      chk("exc_kernel", {31'd0, bus_if.in_kernel}, 32'd1);

      // irq masked in KERNEL for several cycles
      for (int i = 0; i < 4; i++) begin
         chk("kern_mask_ack", {31'd0, bus_if.irq_ack}, 32'd0);
         next_cycle();
         #1;
      end
      bus_if.ID_Z = 1'b1;
      #1;
      chk("kern_br_sel", {29'd0, bus_if.pc_sel}, 32'd1);
      next_cycle();
      bus_if.ID_Z = 1'b0;
      bus_if.ID_Eret = 1'b1;
      set_lu(1'b1);
      #1;
      chk("kern_eret_lu_sel", {29'd0, bus_if.pc_sel},         32'd0);
      chk("kern_eret_lu_pcw", {31'd0, bus_if.PC_IF_ID_Write}, 32'd0);
      next_cycle();
      set_lu(1'b0);
      #1;
      chk("ret2_sel",    {29'd0, bus_if.pc_sel},  32'd6);
      chk("ret2_target", bus_if.pc_target,        32'h0000_0100);
      chk("ret2_ack",    {31'd0, bus_if.irq_ack}, 32'd0);
      next_cycle();
      bus_if.ID_Eret = 1'b0;
      bus_if.ID_PC_plus4 = 32'h0000_0104;
      #1;
      chk("ret2_kernel",   {31'd0, bus_if.in_kernel}, 32'd0);
      chk("post_ret_ack",  {31'd0, bus_if.irq_ack},   32'd1);
      chk("post_ret_sel",  {29'd0, bus_if.pc_sel},    32'd4);
      next_cycle();
      bus_if.irq = 1'b0;
      #1;
      chk("post_ret_epc",    bus_if.epc,                32'h0000_0100);
      chk("post_ret_kernel", {31'd0, bus_if.in_kernel}, 32'd1);

      // double fault leaves state/epc/flushes alone
      bus_if.ID_Illegal = 1'b1;
      bus_if.ID_PC_plus4 = 32'h0000_0200;
      #1;
      chk("df_sel",  {29'd0, bus_if.pc_sel},      32'd0);
      chk("df_ifid", {31'd0, bus_if.IF_ID_Flush}, 32'd0);
      chk("df_idex", {31'd0, bus_if.ID_EX_Flush}, 32'd0);
      next_cycle();
      bus_if.ID_Illegal = 1'b0;
      #1;
      chk("df_flag",   {31'd0, bus_if.double_fault}, 32'd1);
      chk("df_kernel", {31'd0, bus_if.in_kernel},    32'd1);
      chk("df_epc",    bus_if.epc,                   32'h0000_0100);

      // asynchronous reset away from any clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_dfault", {31'd0, bus_if.double_fault}, 32'd0);
      chk("arst_kernel", {31'd0, bus_if.in_kernel},    32'd0);
      chk("arst_epc",    bus_if.epc,                   32'd0);

      // irq_ack latency from a fresh reset
      next_cycle();
      rst_n = 1'b1;
      idle_inputs();
      bus_if.irq = 1'b1;
      for (int i = 0; i < SYNC_LAT; i++) begin
         #1;
         chk("lat_wait_ack", {31'd0, bus_if.irq_ack}, 32'd0);
         next_cycle();
      end
      #1;
      chk("lat_ack", {31'd0, bus_if.irq_ack}, 32'd1);
      next_cycle();
      bus_if.irq = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/hazard_trap_ctrl.md
Name: hazard_trap_ctrl

Overview:
Central pipeline controller for the 5-stage CPU. It resolves load-use stalls and branch/jump/jr flushes, and sequences interrupt and exception entry and return (eret) through a small kernel-mode state machine. It owns the EPC. It drives the IF stage's PC-select and PC_IF_ID_Write, and the flush controls of the IF/ID and ID/EX registers.

Parameters:
IRQ_VECTOR, 32'h80000004, handler address for external interrupt
EXC_VECTOR, 32'h80000008, handler address for illegal-instruction exception

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
ID_valid  in  1  ID stage holds a real instruction (not a bubble)
ID_PC_plus4  in  32  PC+4 of the instruction in ID
ID_Rs  in  5  rs field of the instruction in ID
ID_Rt  in  5  rt field of the instruction in ID
ID_Z  in  1  branch taken, resolved in ID
ID_J  in  1  j/jal in ID
ID_JR  in  1  jr/jalr in ID
ID_Eret  in  1  eret decoded in ID
ID_Illegal  in  1  undefined opcode decoded in ID
EX_MemRead  in  1  the instruction in EX is a load
EX_WriteRegister  in  5  destination register of the instruction in EX
irq  in  1  level interrupt request, held by the source until irq_ack
PC_IF_ID_Write  out  1  0 = hold PC and IF/ID
IF_ID_Flush  out  1  turn IF/ID into a bubble at the next edge
ID_EX_Flush  out  1  turn ID/EX into a bubble at the next edge
pc_sel  out  3  0 PC+4, 1 branch, 2 jump, 3 jr, 4 IRQ_VECTOR, 5 EXC_VECTOR, 6 EPC
pc_target  out  32  vector or EPC; valid when pc_sel >= 4, else 0
epc  out  32  saved return address
in_kernel  out  1  1 while in handler (state KERNEL)
irq_ack  out  1  one-cycle pulse when the interrupt is taken
double_fault  out  1  sticky: ID_Illegal seen while in KERNEL

Behaviour:
- Reset values (registered): state RUN, epc 0, double_fault 0.
- While rst_n is low: PC_IF_ID_Write 1, both flushes 0, pc_sel 0, pc_target 0, irq_ack 0, in_kernel 0.
- Load-use hazard, combinational:
  - lu = EX_MemRead & EX_WriteRegister != 0 & (EX_WriteRegister == ID_Rs | EX_WriteRegister == ID_Rt).
  - On lu: PC_IF_ID_Write 0, ID_EX_Flush 1, pc_sel 0.
  - This gives exactly one stall cycle, because the load leaves EX at the next edge.
- Control priority, evaluated each cycle: trap > eret > lu > branch/jump > normal.
- FSM states: RUN, KERNEL.
- RUN, exception: ID_valid & ID_Illegal, taken even during lu.
  - pc_sel 5, IF_ID_Flush 1, ID_EX_Flush 1.
  - epc <= ID_PC_plus4, so the faulting instruction is skipped.
  - Next state KERNEL.
- RUN, interrupt: irq_eff & ID_valid & !lu & !ID_Illegal.
  - pc_sel 4, IF_ID_Flush 1, ID_EX_Flush 1, irq_ack 1.
  - epc <= ID_PC_plus4 - 4, so the ID instruction is replayed, including a branch/jump in ID.
  - Next state KERNEL.
- irq with ID_valid = 0 waits; no acceptance on a bubble.
- RUN, branch/jump (no trap, no lu):
  - Z -> pc_sel 1, J -> 2, JR -> 3. If more than one is asserted: Z > J > JR.
  - IF_ID_Flush 1.
- KERNEL:
  - irq is masked: irq_ack stays 0.
  - ID_valid & ID_Eret & !lu -> pc_sel 6, pc_target = epc, IF_ID_Flush 1, next state RUN.
  - ID_Illegal sets double_fault; state, epc and flushes are unchanged by it.
  - Branches, jumps and lu are handled as in RUN.
- eret decoded in RUN is a no-op (treated as normal).
- irq arriving in the same cycle as eret: eret completes first. The interrupt can be taken from the first cycle in RUN.
- epc is written only on trap acceptance. It holds its value across KERNEL and after return.
- Reset mid-handler: state returns to RUN and epc to 0 immediately (asynchronous).

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: irq passes through a 2-flop synchronizer (reset 0), so irq_eff lags irq by 2 cycles. irq_ack is generated from irq_eff; the source must hold irq until the ack.
- Undefined: irq_eff = irq, with no added latency.

Test Plan:
- Load-use: EX_MemRead=1, EX_WriteRegister=5, ID_Rs=5 -> one cycle of PC_IF_ID_Write=0 and ID_EX_Flush=1. With EX_WriteRegister=0 -> no stall.
- Branch: ID_Z=1, ID_J=1 same cycle, no hazard -> pc_sel=1, IF_ID_Flush=1, ID_EX_Flush=0.
- Interrupt: irq=1, ID_valid=1, ID_PC_plus4=32'h00000040 -> irq_ack pulse, pc_sel=4, pc_target=32'h80000004, both flushes=1. Next cycle epc=32'h0000003C, in_kernel=1.
- Interrupt on bubble or lu: irq=1 with ID_valid=0 for 3 cycles -> no ack. Ack occurs on the first cycle with ID_valid=1 and no lu.
- Exception + return: ID_Illegal at ID_PC_plus4=32'h100 -> pc_sel=5, epc=32'h100. Later ID_Eret -> pc_sel=6, pc_target=32'h100, in_kernel=0 next cycle. irq held through KERNEL is never acked before the return.
- Double fault and reset: ID_Illegal in KERNEL -> double_fault=1, state unchanged. Then rst_n low -> double_fault=0, in_kernel=0, epc=0 asynchronously. With IRQ_SYNC_EN: irq_ack appears 2 cycles later than without it.
